// File: rtl/f1_reaction_timer.sv
`default_nettype none
// f1_reaction_timer: random hold delay from a 7-bit LFSR, then counts ticks from lights-out
// to the driver's press edge; a press during the hold is reported as a false start. Rev 1.0
module f1_reaction_timer #(
  parameter int WIDTH  = 8,
  parameter int TIME_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [WIDTH-1:0]  lights,
  input  logic              press,
  output logic              lights_out,
  output logic              busy,
  output logic              valid,
  output logic [TIME_W-1:0] react_time,
  output logic              false_start
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    HOLD       = 2'd1,
    TIMING     = 2'd2,
    WAIT_CLEAR = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [6:0]        lfsr_q, lfsr_d;
  logic [6:0]        delay_q, delay_d;
  logic              press_q;
  logic [TIME_W-1:0] timer_q, timer_d;
  logic [TIME_W-1:0] react_q, react_d;
  logic              valid_q, valid_d;
  logic              fs_q, fs_d;
  logic              lights_full;
  logic              press_edge;

  assign lights_full = &lights;
  assign press_edge  = press & ~press_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      lfsr_q  <= 7'h01;
      press_q <= 1'b0;
      delay_q <= 7'd0;
      timer_q <= '0;
      react_q <= '0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      press_q <= press;
      delay_q <= delay_d;
      timer_q <= timer_d;
      react_q <= react_d;
      valid_q <= valid_d;
      fs_q    <= fs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
    delay_d = delay_q;
    timer_d = timer_q;
    react_d = react_q;
    valid_d = 1'b0;
    fs_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (lights_full) begin
          delay_d = lfsr_q;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // A press beats a coincident final tick: the driver jumped the start.
        if (press_edge) begin
          fs_d    = 1'b1;
          state_d = WAIT_CLEAR;
        end else if (tick) begin
          delay_d = delay_q - 7'd1;
          if (delay_q == 7'd1) begin
            timer_d = '0;
            state_d = TIMING;
          end
        end
      end
      TIMING: begin
        if (press_edge) begin
          react_d = timer_q;
          valid_d = 1'b1;
          state_d = WAIT_CLEAR;
        end else if (tick && !(&timer_q)) begin
          timer_d = timer_q + TIME_W'(1);
        end
      end
      WAIT_CLEAR: begin
        if (!lights_full) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign lights_out  = (state_q == TIMING);
  assign busy        = (state_q == HOLD) || (state_q == TIMING);
  assign valid       = valid_q;
  assign false_start = fs_q;
  assign react_time  = react_q;

endmodule
`default_nettype wire

// File: tb/tb_f1_reaction_timer.sv
`default_nettype none
// tb_f1_reaction_timer: directed and random stimulus on two instances (TIME_W 16 and 4),
// checked against a tick-counting reference model through a pulse scoreboard.
module tb_f1_reaction_timer;

  localparam int P_IDLE = 0, P_HOLD = 1, P_TIMING = 2, P_WC = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic [7:0]  lights = 8'h00;
  logic        press = 1'b0;

  logic        lo16, busy16, v16, fs16;
  logic [15:0] rt16;
  logic        lo4, busy4, v4, fs4;
  logic [3:0]  rt4;

  f1_reaction_timer u_dut16 (
    .clk(clk), .rst(rst), .tick(tick), .lights(lights), .press(press),
    .lights_out(lo16), .busy(busy16), .valid(v16), .react_time(rt16), .false_start(fs16)
  );

  f1_reaction_timer #(.WIDTH(8), .TIME_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .tick(tick), .lights(lights), .press(press),
    .lights_out(lo4), .busy(busy4), .valid(v4), .react_time(rt4), .false_start(fs4)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit fs;
    int r16;
    int r4;
  } exp_t;

  exp_t sb[$];
  exp_t sb_e;

  int  total = 0;
  int  bad = 0;
  bit  started = 0;

  // Reference model: phase, remaining hold ticks, unbounded elapsed tick count
  int  m_phase = P_IDLE;
  int  m_lfsr = 1;
  bit  m_prev = 0;
  int  m_rem = 0;
  int  m_ticks = 0;
  int  m_r16 = 0;
  int  m_r4 = 0;
  bit  e_valid = 0;
  bit  e_fs = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model(input logic r, input logic t, input logic [7:0] l, input logic p);
    bit pe;
    bit full;
    e_valid = 0;
    e_fs = 0;
    if (!r) begin
      m_phase = P_IDLE; m_lfsr = 1; m_prev = 0; m_rem = 0; m_ticks = 0;
      m_r16 = 0; m_r4 = 0; started = 1;
    end else begin
      pe = p && !m_prev;
      full = (l == 8'hFF);
      case (m_phase)
        P_IDLE: if (full) begin m_rem = m_lfsr; m_phase = P_HOLD; end
        P_HOLD: begin
          if (pe) begin
            e_fs = 1;
            sb.push_back('{1'b1, m_r16, m_r4});
            m_phase = P_WC;
          end else if (t) begin
            m_rem--;
            if (m_rem == 0) begin m_ticks = 0; m_phase = P_TIMING; end
          end
        end
        P_TIMING: begin
          if (pe) begin
            m_r16 = (m_ticks > 65535) ? 65535 : m_ticks;
            m_r4  = (m_ticks > 15) ? 15 : m_ticks;
            e_valid = 1;
            sb.push_back('{1'b0, m_r16, m_r4});
            m_phase = P_WC;
          end else if (t) begin
            m_ticks++;
          end
        end
        default: if (!full) m_phase = P_IDLE;
      endcase
      m_prev = p;
      m_lfsr = ((m_lfsr << 1) & 'h7E) | (((m_lfsr >> 6) ^ (m_lfsr >> 5)) & 1);
    end
  endtask

  task automatic step(input logic r, input logic t, input logic [7:0] l, input logic p);
    rst = r; tick = t; lights = l; press = p;
    @(posedge clk);
    model(r, t, l, p);
    #1;
  endtask

  task automatic wait_lights_out(input logic p);
    int n;
    n = 0;
    while (!lo16 && n < 300) begin
      step(1'b1, 1'b1, 8'hFF, p);
      n++;
    end
    chk("wait_lights_out", lo16, 1);
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("lights_out", lo16, m_phase == P_TIMING);
      chk("lights_out_w4", lo4, m_phase == P_TIMING);
      chk("busy", busy16, (m_phase == P_HOLD) || (m_phase == P_TIMING));
      chk("busy_w4", busy4, (m_phase == P_HOLD) || (m_phase == P_TIMING));
      chk("valid", v16, e_valid);
      chk("valid_w4", v4, e_valid);
      chk("false_start", fs16, e_fs);
      chk("false_start_w4", fs4, e_fs);
      chk("react_time", rt16, m_r16);
      chk("react_time_w4", rt4, m_r4);
      if (v16 || fs16) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected_pulse: got valid=%0b false_start=%0b expected none", v16, fs16);
        end else begin
          sb_e = sb.pop_front();
          chk("sb_kind_false_start", fs16, sb_e.fs);
          chk("sb_react", rt16, sb_e.r16);
          chk("sb_react_w4", rt4, sb_e.r4);
        end
      end
    end
  end

  initial begin
    int  n;
    logic pr;
    logic [7:0] lr;

    repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("reset_lights_out", lo16, 0);
    chk("reset_busy", busy16, 0);
    chk("reset_react", rt16, 0);

    // Known LFSR value 8'h08 at arming; tick every cycle
    repeat (3) step(1'b1, 1'b1, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'hFF, 1'b0);
    chk("arm_busy", busy16, 1);
    n = 0;
    while (!lo16 && n < 300) begin
      step(1'b1, 1'b1, 8'hFF, 1'b0);
      n++;
    end
    chk("hold_ticks", n, 8);
    repeat (5) step(1'b1, 1'b1, 8'hFF, 1'b0);
    step(1'b1, 1'b1, 8'hFF, 1'b1);
    chk("react_5", rt16, 5);
    chk("react_5_w4", rt4, 5);
    chk("valid_pulse", v16, 1);
    chk("lights_out_fall", lo16, 0);
    repeat (4) step(1'b1, 1'b1, 8'hFF, 1'b1);
    chk("wait_clear_no_rearm", busy16, 0);
    step(1'b1, 1'b1, 8'h7F, 1'b0);

    // False start on the same cycle as the final hold tick
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'hFF, 1'b0);
    n = 0;
    while (m_rem != 1 && n < 300) begin
      step(1'b1, 1'b1, 8'hFF, 1'b0);
      n++;
    end
    step(1'b1, 1'b1, 8'hFF, 1'b1);
    chk("fs_pulse", fs16, 1);
    chk("fs_no_lights_out", lo16, 0);
    chk("fs_react_kept", rt16, 5);
    step(1'b1, 1'b1, 8'hFF, 1'b1);
    chk("fs_single_pulse", fs16, 0);
    step(1'b1, 1'b1, 8'h00, 1'b0);

    // Press held from before arming: never an edge
    step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b1, 8'hFF, 1'b1);
    wait_lights_out(1'b1);
    repeat (3) step(1'b1, 1'b1, 8'hFF, 1'b1);
    step(1'b1, 1'b1, 8'hFF, 1'b0);
    step(1'b1, 1'b1, 8'hFF, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0);

    // Saturation: 20 ticks before the press
    step(1'b1, 1'b0, 8'hFF, 1'b0);
    wait_lights_out(1'b0);
    repeat (20) step(1'b1, 1'b1, 8'hFF, 1'b0);
    step(1'b1, 1'b1, 8'hFF, 1'b1);
    chk("sat_react_w4", rt4, 15);
    chk("sat_react_w16", rt16, 20);
    step(1'b1, 1'b0, 8'h00, 1'b0);

    // Reset during TIMING and during HOLD
    step(1'b1, 1'b0, 8'hFF, 1'b0);
    wait_lights_out(1'b0);
    repeat (3) step(1'b1, 1'b1, 8'hFF, 1'b0);
    step(1'b0, 1'b1, 8'hFF, 1'b1);
    chk("rst_timing_lights_out", lo16, 0);
    chk("rst_timing_busy", busy16, 0);
    chk("rst_timing_react", rt16, 0);
    chk("rst_timing_valid", v16, 0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'hFF, 1'b0);
    step(1'b0, 1'b1, 8'hFF, 1'b1);
    chk("rst_hold_busy", busy16, 0);
    chk("rst_hold_false_start", fs16, 0);

    // Random traffic
    pr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) pr = ~pr;
      lr = ($urandom_range(2) != 0) ? 8'hFF : 8'($urandom);
      step(($urandom_range(399) != 0), 1'($urandom), lr, pr);
    end

    repeat (5) step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/f1_reaction_timer.md
F1_REACTION_TIMER -- requirements
Module: f1_reaction_timer

Interface
REQ-001 Parameter WIDTH, default 8: width of the start-light vector consumed from the light-sequence FSM.
REQ-002 Parameter TIME_W, default 16: width of the reaction-time counter and result.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
REQ-005 tick  input  1  timebase pulse, one clk cycle wide; all delays and times are counted in ticks.
REQ-006 lights  input  WIDTH  start-light pattern from the upstream sequencer; all-ones means fully lit.
REQ-007 press  input  1  driver button, level, already synchronised to clk.
REQ-008 lights_out  output  1  high while lights are extinguished and timing runs.
REQ-009 busy  output  1  high in HOLD or TIMING.
REQ-010 valid  output  1  one-cycle pulse when react_time is updated.
REQ-011 react_time  output  TIME_W  last measured reaction time in ticks; held until the next valid.
REQ-012 false_start  output  1  one-cycle pulse on a press during HOLD.

Function
REQ-013 The block SHALL contain a 7-bit Fibonacci LFSR that advances every clk cycle as next = {lfsr[5:0], lfsr[6]^lfsr[5]}, with seed 7'h01.
REQ-014 Press edge SHALL be press & ~press_q, where press_q is press registered one cycle; a level already held at arming is not an edge.
REQ-015 The FSM SHALL have states IDLE, HOLD, TIMING and WAIT_CLEAR.
REQ-016 IDLE: when lights is all ones, load delay = current lfsr value (zero-extended) and go to HOLD; otherwise stay in IDLE.
REQ-017 HOLD: on tick, decrement delay; a tick with delay==1 SHALL clear timer to 0 and go to TIMING, so lights_out rises D ticks after arming.
REQ-018 HOLD: a press edge SHALL pulse false_start, leave react_time unchanged, and go to WAIT_CLEAR; this wins over a simultaneous final tick.
REQ-019 TIMING: on tick, increment timer, saturating at all ones (no wrap).
REQ-020 TIMING: a press edge SHALL load react_time with the timer value before any same-cycle increment, pulse valid, and go to WAIT_CLEAR.
REQ-021 WAIT_CLEAR: go to IDLE when lights is not all ones; this prevents re-arming on a pattern that stays lit.
REQ-022 lights_out SHALL be 1 exactly in TIMING; busy SHALL be 1 exactly in HOLD or TIMING.
REQ-023 Changes on lights while in HOLD or TIMING SHALL be ignored.
REQ-024 Press edges in IDLE or WAIT_CLEAR SHALL be ignored.

Reset
REQ-025 With rst low at a clk edge, these registers SHALL load: state=IDLE, lfsr=7'h01, press_q=0, delay=0, timer=0, react_time=0.
REQ-026 Outputs during and immediately after reset SHALL be: lights_out=0, busy=0, valid=0, false_start=0.
REQ-027 Reset mid-HOLD or mid-TIMING SHALL abort without any valid or false_start pulse.

Verification
REQ-028 Reset release, then lights=0 for 3 cycles, then lights=8'hFF (lfsr=7'h08), tick every cycle, no press -> lights_out rises after 8 ticks, and busy is high from the cycle after arming.
REQ-029 Continue REQ-028 with press rising after 5 further ticks -> valid pulses once, react_time=5, lights_out falls, and the state is WAIT_CLEAR until lights drops below 8'hFF.
REQ-030 Press edge during HOLD, including the same cycle as the final tick -> false_start pulses once, lights_out never rises, and react_time keeps its old value.
REQ-031 TIME_W=4, no press in TIMING for 20 ticks -> timer holds at 15; a later press gives react_time=15.
REQ-032 Press held high from before arming, never released -> no false_start and no valid; lights_out still rises after D ticks.
REQ-033 rst low during TIMING -> next cycle lights_out=0, busy=0, react_time=0, and no valid pulse.
